// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller (master) consumes instruction fields and flags and drives the mux selects and write enables.
interface multicycle_controller_if #(
    parameter int CTRL_WIDTH  = 3,
    parameter int STATE_WIDTH = 4
);
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic                   funct7_5;
    logic                   zero;
    logic                   mem_ready;
    logic [CTRL_WIDTH-1:0]  alu_control;
    logic [1:0]             alu_src_a;
    logic [1:0]             alu_src_b;
    logic [1:0]             result_src;
    logic [2:0]             imm_src;
    logic                   adr_src;
    logic                   ir_write;
    logic                   pc_write;
    logic                   reg_write;
    logic                   mem_write;
    logic                   retire;
    logic                   trap;
    logic [STATE_WIDTH-1:0] state_o;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, retire, trap, state_o
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, retire, trap, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I-subset core: sequences fetch/decode/execute/memory/writeback.
// Outputs decode combinationally from the state so memory handshakes (ir_write, mem_write) react within the cycle.
module multicycle_controller #(
    parameter int STATE_WIDTH = 4,
    parameter int CTRL_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [CTRL_WIDTH-1:0] ALU_ADD = CTRL_WIDTH'(3'b000);
    localparam logic [CTRL_WIDTH-1:0] ALU_SUB = CTRL_WIDTH'(3'b001);
    localparam logic [CTRL_WIDTH-1:0] ALU_AND = CTRL_WIDTH'(3'b010);
    localparam logic [CTRL_WIDTH-1:0] ALU_OR  = CTRL_WIDTH'(3'b011);
    localparam logic [CTRL_WIDTH-1:0] ALU_XOR = CTRL_WIDTH'(3'b100);
    localparam logic [CTRL_WIDTH-1:0] ALU_SLT = CTRL_WIDTH'(3'b101);
    localparam logic [CTRL_WIDTH-1:0] ALU_SLL = CTRL_WIDTH'(3'b110);
    localparam logic [CTRL_WIDTH-1:0] ALU_SRL = CTRL_WIDTH'(3'b111);

    function automatic logic [CTRL_WIDTH-1:0] alu_dec(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_dec = sub ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

    state_t                r_state;
    state_t                w_dec_next;
    logic [CTRL_WIDTH-1:0] w_alu;
    logic [1:0]            w_src_a, w_src_b, w_res;
    logic [2:0]            w_imm;
    logic                  w_adr, w_ir, w_pc, w_rw, w_mw, w_ret, w_trap;

    // Decode-stage dispatch; unsupported encodings (sltu, srai-style shifts, R-type funct7 variants) trap
    always_comb begin
        w_dec_next = S_TRAP;
        case (bus.opcode)
            OP_LW, OP_SW: w_dec_next = (bus.funct3 == 3'b011) ? S_TRAP : S_MEMADR;
            OP_R:   w_dec_next = ((bus.funct3 == 3'b011) || (bus.funct7_5 && (bus.funct3 != 3'b000)))
                                 ? S_TRAP : S_EXEC_R;
            OP_I:   w_dec_next = ((bus.funct3 == 3'b011) ||
                                  (bus.funct7_5 && ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b101))))
                                 ? S_TRAP : S_EXEC_I;
            OP_BR:  w_dec_next = ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b001)) ? S_BRANCH : S_TRAP;
            OP_JAL: w_dec_next = S_JAL;
            default: w_dec_next = S_TRAP;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    r_state <= bus.mem_ready ? S_DECODE : S_FETCH;
                S_DECODE:   r_state <= w_dec_next;
                S_MEMADR:   r_state <= (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  r_state <= bus.mem_ready ? S_MEMWB : S_MEMREAD;
                S_MEMWRITE: r_state <= bus.mem_ready ? S_FETCH : S_MEMWRITE;
                S_EXEC_R, S_EXEC_I, S_JAL: r_state <= S_ALUWB;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Datapath control decode from current state
    always_comb begin
        w_alu   = ALU_ADD;
        w_src_a = 2'b00;
        w_src_b = 2'b00;
        w_res   = 2'b00;
        w_adr   = 1'b0;
        w_ir    = 1'b0;
        w_pc    = 1'b0;
        w_rw    = 1'b0;
        w_mw    = 1'b0;
        w_ret   = 1'b0;
        w_trap  = 1'b0;
        case (bus.opcode)
            OP_SW:   w_imm = 3'b001;
            OP_BR:   w_imm = 3'b010;
            OP_JAL:  w_imm = 3'b011;
            default: w_imm = 3'b000;
        endcase
        case (r_state)
            S_FETCH: begin
                w_src_b = 2'b10;
                w_res   = 2'b10;
                w_ir    = bus.mem_ready;
                w_pc    = bus.mem_ready;
            end
            S_DECODE: begin
                w_src_a = 2'b01;
                w_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_src_a = 2'b10;
                w_src_b = 2'b01;
            end
            S_MEMREAD: w_adr = 1'b1;
            S_MEMWB: begin
                w_res = 2'b01;
                w_rw  = 1'b1;
                w_ret = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr = 1'b1;
                w_mw  = 1'b1;
                w_ret = bus.mem_ready;
            end
            S_EXEC_R: begin
                w_src_a = 2'b10;
                w_alu   = alu_dec(bus.funct3, bus.funct7_5);
            end
            S_EXEC_I: begin
                w_src_a = 2'b10;
                w_src_b = 2'b01;
                w_alu   = alu_dec(bus.funct3, 1'b0);
            end
            S_ALUWB: begin
                w_rw  = 1'b1;
                w_ret = 1'b1;
            end
            S_BRANCH: begin
                w_src_a = 2'b10;
                w_alu   = ALU_SUB;
                w_pc    = bus.zero ^ bus.funct3[0];
                w_ret   = 1'b1;
            end
            S_JAL: begin
                w_src_a = 2'b01;
                w_src_b = 2'b10;
                w_pc    = 1'b1;
            end
            S_TRAP:  w_trap = 1'b1;
            default: w_trap = 1'b0;
        endcase
    end

    assign bus.alu_control = w_alu;
    assign bus.alu_src_a   = w_src_a;
    assign bus.alu_src_b   = w_src_b;
    assign bus.result_src  = w_res;
    assign bus.imm_src     = w_imm;
    assign bus.adr_src     = w_adr;
    // Reset must silence every enable at once, even mid memory write
    assign bus.ir_write    = w_ir   & ~rst;
    assign bus.pc_write    = w_pc   & ~rst;
    assign bus.reg_write   = w_rw   & ~rst;
    assign bus.mem_write   = w_mw   & ~rst;
    assign bus.retire      = w_ret  & ~rst;
    assign bus.trap        = w_trap & ~rst;
    assign bus.state_o     = STATE_WIDTH'(r_state);
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized instruction stream
// compared against a per-instruction-class reference model (state path, cycle count, enable counts).
module tb_multicycle_controller;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam int MAXC = 30;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    multicycle_controller_if #(.CTRL_WIDTH(3), .STATE_WIDTH(4)) bus ();
    multicycle_controller #(.STATE_WIDTH(4), .CTRL_WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] ob_st  [32];
    logic [2:0] ob_alu [32];
    logic [2:0] ob_imm [32];
    logic [1:0] ob_rs  [32];
    logic       ob_ir  [32];
    logic       ob_pc  [32];
    logic       ob_rw  [32];
    logic       ob_mw  [32];
    logic       ob_ret [32];
    logic       ob_trap[32];
    logic [2:0] alu_tab[8];

    function automatic int cnt_of(input logic a[32], input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += int'(a[k]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; stalls mem_ready wf cycles in FETCH and wm in MEMREAD/MEMWRITE.
    // Records every cycle; stops after the retire cycle or MAXC cycles.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic z, input int wf, input int wm, output int n);
        int fw = wf;
        int mw = wm;
        n = 0;
        bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f75; bus.zero = z;
        for (int c = 0; c < MAXC; c++) begin
            if (bus.state_o == 4'd0 && fw > 0) begin
                bus.mem_ready = 1'b0; fw--;
            end else if ((bus.state_o == 4'd3 || bus.state_o == 4'd5) && mw > 0) begin
                bus.mem_ready = 1'b0; mw--;
            end else if (bus.state_o == 4'd0 || bus.state_o == 4'd3 || bus.state_o == 4'd5) begin
                bus.mem_ready = 1'b1;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            ob_st[c] = bus.state_o;   ob_alu[c] = bus.alu_control; ob_imm[c] = bus.imm_src;
            ob_rs[c] = bus.result_src; ob_ir[c] = bus.ir_write;    ob_pc[c] = bus.pc_write;
            ob_rw[c] = bus.reg_write;  ob_mw[c] = bus.mem_write;   ob_ret[c] = bus.retire;
            ob_trap[c] = bus.trap;
            n = c + 1;
            tick();
            if (ob_ret[c]) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_R; bus.funct3 = 3'b000;
        bus.funct7_5 = 1'b0; bus.zero = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.retire, bus.trap} !== 6'b0) begin
            errors++; $display("FAIL reset_enables: got %b expected 000000",
                {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.retire, bus.trap});
        end
        bus.mem_ready = 1'b0; rst = 1'b0;
        tick();
        checks++;
        if (bus.state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
        // drive a store into MEMWRITE wait, then reset mid-access
        bus.opcode = OP_SW; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state_o !== 4'd5 || bus.mem_write !== 1'b1) begin
            errors++; $display("FAIL memwrite_wait: got state %0d mw %b expected 5 1", bus.state_o, bus.mem_write);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_write !== 1'b0 || bus.trap !== 1'b0) begin
            errors++; $display("FAIL rst_drop_mw: got mw %b trap %b expected 0 0", bus.mem_write, bus.trap);
        end
        @(negedge clk); rst = 1'b0;
        tick();
        checks++;
        if (bus.state_o !== 4'd0) begin errors++; $display("FAIL rst_restart: got %0d expected 0", bus.state_o); end
    endtask

    task automatic test_r_sub();
        int n;
        run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0, n);
        checks++;
        if (n !== 4 || ob_st[0] !== 4'd0 || ob_st[1] !== 4'd1 || ob_st[2] !== 4'd6 || ob_st[3] !== 4'd8) begin
            errors++; $display("FAIL rsub_path: got n=%0d %0d,%0d,%0d,%0d expected 4: 0,1,6,8",
                n, ob_st[0], ob_st[1], ob_st[2], ob_st[3]);
        end
        checks++;
        if (ob_alu[2] !== 3'b001) begin errors++; $display("FAIL rsub_alu: got %b expected 001", ob_alu[2]); end
        checks++;
        if (cnt_of(ob_rw, n) !== 1 || ob_rw[3] !== 1'b1 || cnt_of(ob_ret, n) !== 1 || ob_ret[3] !== 1'b1) begin
            errors++; $display("FAIL rsub_wb: got rw=%0d ret=%0d expected one each in ALUWB",
                cnt_of(ob_rw, n), cnt_of(ob_ret, n));
        end
        checks++;
        if (bus.state_o !== 4'd0) begin errors++; $display("FAIL rsub_next: got %0d expected 0", bus.state_o); end
    endtask

    task automatic test_branch();
        logic [2:0] f3s [3];
        logic       zs  [3];
        logic       tk  [3];
        int n;
        f3s[0] = 3'b000; zs[0] = 1'b1; tk[0] = 1'b1;
        f3s[1] = 3'b000; zs[1] = 1'b0; tk[1] = 1'b0;
        f3s[2] = 3'b001; zs[2] = 1'b0; tk[2] = 1'b1;
        for (int v = 0; v < 3; v++) begin
            run_instr(OP_BR, f3s[v], 1'($urandom_range(0, 1)), zs[v], 0, 0, n);
            checks++;
            if (n !== 3 || ob_st[2] !== 4'd9) begin
                errors++; $display("FAIL branch%0d_len: got n=%0d st=%0d expected 3 9", v, n, ob_st[2]);
            end
            checks++;
            if (ob_pc[2] !== tk[v] || ob_alu[2] !== 3'b001) begin
                errors++; $display("FAIL branch%0d_pc: got pc=%b alu=%b expected %b 001", v, ob_pc[2], ob_alu[2], tk[v]);
            end
        end
    endtask

    task automatic test_lw_waits();
        logic [3:0] exp_st [10];
        int n;
        exp_st[0] = 4'd0; exp_st[1] = 4'd0; exp_st[2] = 4'd0; exp_st[3] = 4'd1; exp_st[4] = 4'd2;
        exp_st[5] = 4'd3; exp_st[6] = 4'd3; exp_st[7] = 4'd3; exp_st[8] = 4'd3; exp_st[9] = 4'd4;
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 2, 3, n);
        checks++;
        if (n !== 10) begin
            errors++; $display("FAIL lw_cycles: got %0d expected 10", n);
        end else begin
            for (int c = 0; c < 10; c++) begin
                checks++;
                if (ob_st[c] !== exp_st[c]) begin
                    errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", c, ob_st[c], exp_st[c]);
                end
            end
            checks++;
            if (cnt_of(ob_ir, n) !== 1 || cnt_of(ob_rw, n) !== 1 || ob_rw[9] !== 1'b1 || ob_rs[9] !== 2'b01) begin
                errors++; $display("FAIL lw_enables: got ir=%0d rw=%0d rs=%b expected 1 1 01",
                    cnt_of(ob_ir, n), cnt_of(ob_rw, n), ob_rs[9]);
            end
        end
    endtask

    task automatic test_slli();
        int n;
        run_instr(OP_I, 3'b001, 1'b0, 1'b0, 0, 0, n);
        checks++;
        if (n !== 4 || ob_st[2] !== 4'd7 || ob_alu[2] !== 3'b110) begin
            errors++; $display("FAIL slli: got n=%0d st=%0d alu=%b expected 4 7 110", n, ob_st[2], ob_alu[2]);
        end
    endtask

    task automatic test_trap();
        int n;
        int ntrap;
        run_instr(OP_I, 3'b101, 1'b1, 1'b0, 0, 0, n);
        ntrap = cnt_of(ob_trap, n);
        checks++;
        if (n !== MAXC || ob_st[2] !== 4'd15 || ntrap !== MAXC - 2) begin
            errors++; $display("FAIL srai_trap: got n=%0d st=%0d trapcyc=%0d expected %0d 15 %0d",
                n, ob_st[2], ntrap, MAXC, MAXC - 2);
        end
        checks++;
        if (cnt_of(ob_rw, n) + cnt_of(ob_mw, n) + cnt_of(ob_ret, n) + cnt_of(ob_pc, n) !== 1) begin
            errors++; $display("FAIL trap_enables: got %0d enable cycles expected 1 (fetch pc_write)",
                cnt_of(ob_rw, n) + cnt_of(ob_mw, n) + cnt_of(ob_ret, n) + cnt_of(ob_pc, n));
        end
        rst = 1'b1; bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.trap !== 1'b0) begin errors++; $display("FAIL trap_clear: got %b expected 0", bus.trap); end
        @(negedge clk); rst = 1'b0;
        tick();
        checks++;
        if (bus.state_o !== 4'd0) begin errors++; $display("FAIL trap_restart: got %0d expected 0", bus.state_o); end
    endtask

    task automatic test_jal();
        int n;
        run_instr(OP_JAL, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 0, 0, n);
        checks++;
        if (n !== 4 || ob_st[0] !== 4'd0 || ob_st[1] !== 4'd1 || ob_st[2] !== 4'd10 || ob_st[3] !== 4'd8) begin
            errors++; $display("FAIL jal_path: got n=%0d %0d,%0d,%0d,%0d expected 4: 0,1,10,8",
                n, ob_st[0], ob_st[1], ob_st[2], ob_st[3]);
        end
        checks++;
        if (ob_pc[2] !== 1'b1 || ob_rw[3] !== 1'b1 || cnt_of(ob_rw, n) !== 1) begin
            errors++; $display("FAIL jal_wr: got pc=%b rw=%b expected 1 1", ob_pc[2], ob_rw[3]);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ob_imm[c] !== 3'b011) begin errors++; $display("FAIL jal_imm[%0d]: got %b expected 011", c, ob_imm[c]); end
        end
    endtask

    // Random legal instructions against a class-level model of path, latency and write activity
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int cls = $urandom_range(0, 5);
            int wf  = $urandom_range(0, 2);
            int wm  = $urandom_range(0, 3);
            logic [6:0] op;
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic f75 = 1'($urandom_range(0, 1));
            logic z   = 1'($urandom_range(0, 1));
            logic [2:0] imm_e, alu_e;
            int rw_e, pc_e, mw_e, n;
            int exp_st[$];
            for (int k = 0; k <= wf; k++) exp_st.push_back(0);
            exp_st.push_back(1);
            rw_e = 1; pc_e = 1; mw_e = 0; imm_e = 3'b000;
            case (cls)
                0: begin op = OP_LW; f3 = 3'b010; exp_st.push_back(2);
                         for (int k = 0; k <= wm; k++) exp_st.push_back(3);
                         exp_st.push_back(4); end
                1: begin op = OP_SW; f3 = 3'b010; exp_st.push_back(2); imm_e = 3'b001; rw_e = 0;
                         for (int k = 0; k <= wm; k++) exp_st.push_back(5);
                         mw_e = wm + 1; end
                2: begin op = OP_R; if (f3 == 3'b011) f3 = 3'b010;
                         if (f3 != 3'b000) f75 = 1'b0;
                         exp_st.push_back(6); exp_st.push_back(8); end
                3: begin op = OP_I; if (f3 == 3'b011) f3 = 3'b111;
                         if (f3 == 3'b001 || f3 == 3'b101) f75 = 1'b0;
                         exp_st.push_back(7); exp_st.push_back(8); end
                4: begin op = OP_BR; f3 = {2'b00, f3[0]}; exp_st.push_back(9); imm_e = 3'b010; rw_e = 0;
                         pc_e = 1 + int'(z != f3[0]); end
                default: begin op = OP_JAL; exp_st.push_back(10); exp_st.push_back(8); imm_e = 3'b011;
                         pc_e = 2; end
            endcase
            alu_e = (cls == 2 && f3 == 3'b000 && f75) ? 3'b001 : alu_tab[f3];
            run_instr(op, f3, f75, z, wf, wm, n);
            checks++;
            if (n !== exp_st.size()) begin
                errors++; $display("FAIL rnd%0d_cycles: cls %0d got %0d expected %0d", it, cls, n, exp_st.size());
            end else begin
                for (int c = 0; c < n; c++) begin
                    checks++;
                    if (ob_st[c] !== 4'(exp_st[c]) || ob_imm[c] !== imm_e) begin
                        errors++; $display("FAIL rnd%0d_cyc%0d: got st=%0d imm=%b expected %0d %b",
                            it, c, ob_st[c], ob_imm[c], exp_st[c], imm_e);
                    end
                    if (exp_st[c] == 6 || exp_st[c] == 7) begin
                        checks++;
                        if (ob_alu[c] !== alu_e) begin
                            errors++; $display("FAIL rnd%0d_alu: got %b expected %b", it, ob_alu[c], alu_e);
                        end
                    end
                end
                checks++;
                if (cnt_of(ob_ir, n) !== 1 || cnt_of(ob_rw, n) !== rw_e || cnt_of(ob_pc, n) !== pc_e ||
                    cnt_of(ob_mw, n) !== mw_e || cnt_of(ob_ret, n) !== 1 || ob_ret[n-1] !== 1'b1) begin
                    errors++; $display("FAIL rnd%0d_counts: got ir%0d rw%0d pc%0d mw%0d ret%0d expected 1 %0d %0d %0d 1",
                        it, cnt_of(ob_ir, n), cnt_of(ob_rw, n), cnt_of(ob_pc, n), cnt_of(ob_mw, n),
                        cnt_of(ob_ret, n), rw_e, pc_e, mw_e);
                end
            end
            checks++;
            if (bus.state_o !== 4'd0) begin errors++; $display("FAIL rnd%0d_next: got %0d expected 0", it, bus.state_o); end
        end
    endtask

    initial begin
        alu_tab[0] = 3'b000; alu_tab[1] = 3'b110; alu_tab[2] = 3'b101; alu_tab[3] = 3'b000;
        alu_tab[4] = 3'b100; alu_tab[5] = 3'b111; alu_tab[6] = 3'b011; alu_tab[7] = 3'b010;
        test_reset();
        test_r_sub();
        test_branch();
        test_lw_waits();
        test_slli();
        test_trap();
        test_jal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
